rs_encode_stream_in_sched: RTL and testbench
============================================

RS_ENCODE_STREAM_IN_SCHED -- requirements
Module: rs_encode_stream_in_sched

Interface
REQ-001 SHALL have parameter NUM_RS_UNITS, default 4, meaning the number of RS encode units (>=1, not necessarily a power of 2).
REQ-002 SHALL have parameter NUM_RS_UNITS_W, default $clog2(NUM_RS_UNITS) (min 1), meaning the unit-select width.
REQ-003 SHALL have parameter LINE_CNT_W, default 8, meaning the data-lines-per-block field width.
REQ-004 SHALL have parameter BLOCK_CNT_W, default 16, meaning the blocks-per-request field width.
REQ-005 SHALL have parameter PAD_LINES, default 1, meaning the pad (parity-slot) lines issued after each block's data (>=1).
REQ-006 SHALL have parameter RR_PERSIST, default 0, meaning 1 = unit select continues across requests, 0 = unit select restarts at 0 per request.
REQ-007 Ports, in this order:
  clk  in  1  clock, the single clock domain.
  rst  in  1  asynchronous reset, active high.
  src_req_val  in  1  request valid.
  src_req_rdy  out  1  request ready.
  src_req_num_blocks  in  BLOCK_CNT_W  blocks in this request.
  src_req_lines  in  LINE_CNT_W  data lines per block.
  src_data_val  in  1  data line valid.
  src_data_rdy  out  1  data line ready.
  unit_val  out  NUM_RS_UNITS  one-hot line valid to the selected unit.
  unit_rdy  in  NUM_RS_UNITS  per-unit ready.
  unit_pad  out  1  current line is a pad line; datapath drives zeros.
  unit_last  out  1  current line is the final line of the block.
  rs_unit_sel  out  NUM_RS_UNITS_W  selected unit index.
  meta_val  out  1  metadata valid to the output controller.
  meta_rdy  in  1  metadata ready.
  busy  out  1  high in any state other than IDLE.

Function
REQ-008 Main FSM SHALL have states IDLE, DATA, PAD and DRAIN.
REQ-009 In IDLE: src_req_rdy=1; on src_req_val it SHALL latch num_blocks and lines, clear the line, pad and block counters, and load sel (0 if RR_PERSIST=0); it SHALL then go to DATA if num_blocks!=0 and lines!=0, to PAD if num_blocks!=0 and lines==0, and to DRAIN if num_blocks==0.
REQ-010 The metadata FSM (M_IDLE, M_PASS, M_DONE) SHALL move M_IDLE->M_PASS on request acceptance, hold meta_val=1 in M_PASS until meta_rdy, then go to M_DONE.
REQ-011 M_DONE SHALL return to M_IDLE in the cycle the main FSM is in DRAIN.
REQ-012 Metadata SHALL proceed concurrently with data and SHALL never block DATA or PAD.
REQ-013 In DATA, the block SHALL drive unit_val[sel]=src_data_val and src_data_rdy=unit_rdy[sel] combinationally (zero latency, no buffering); all other unit_val bits SHALL be 0.
REQ-014 On a DATA handshake the block SHALL increment the line count; on the handshake of line lines-1 it SHALL clear the line count and go to PAD.
REQ-015 In PAD: unit_val[sel]=1, unit_pad=1, src_data_rdy=0; each unit_rdy[sel] SHALL increment the pad count.
REQ-016 On the handshake of the last pad line the block SHALL clear the pad count and increment the block count; sel SHALL advance modulo NUM_RS_UNITS (NUM_RS_UNITS-1 wraps to 0).
REQ-017 After the last pad line, the block SHALL go to DRAIN if the finished block is block num_blocks-1; otherwise it SHALL go to DATA, or stay in PAD if lines==0.
REQ-018 unit_last SHALL be 1 only on the final pad line.
REQ-019 The sel advance SHALL also occur after the last block, so that RR_PERSIST=1 starts the next request on the next unit.
REQ-020 In DRAIN all valids and readies SHALL be 0; the block SHALL go to IDLE when the metadata FSM is in M_DONE, and in the same cycle if it is already there.
REQ-021 Counters SHALL use full field width without overflow: num_blocks up to 2^BLOCK_CNT_W-1 and lines up to 2^LINE_CNT_W-1.
REQ-022 src_req_rdy SHALL be 0 outside IDLE, so a new request is accepted only after DRAIN completes.
REQ-023 unit_rdy bits of unselected units SHALL be ignored.
REQ-024 A request arriving in the IDLE cycle entered from DRAIN SHALL be accepted.

Reset
REQ-025 rst SHALL asynchronously force IDLE, M_IDLE, all counters 0 and sel 0, including mid-request; in-flight requests are discarded.
REQ-026 Outputs during reset SHALL be: src_req_rdy=1, and src_data_rdy, unit_val, unit_pad, unit_last, rs_unit_sel, meta_val and busy all 0.

Structure
REQ-027 A shared package rs_encode_pkg SHALL hold the main and metadata state enums; no other shared constants are required.
REQ-028 A sub-module rs_rr_sel SHALL implement the modulo-N wrapping selector with a binary index output and a one-hot decode.

Verification
REQ-029 NUM_RS_UNITS=3, lines=4, num_blocks=4, meta_rdy=1: response SHALL be units 0,1,2,0, each getting 4 data lines + 1 pad with unit_last on the pad line, and busy low 1 cycle after DRAIN.
REQ-030 Random unit_rdy/src_data_val stalls, lines=255: response SHALL be exactly 255 data handshakes per block, with no line lost or duplicated.
REQ-031 meta_rdy held 0 for 50 cycles, 1 block of 2 lines: response SHALL be that the data completes, the block waits in DRAIN, and returns to IDLE 1 cycle after meta_rdy.
REQ-032 num_blocks=0, then lines=0 with num_blocks=2 and PAD_LINES=2: response SHALL be metadata only for the first request, and for the second, 2 pad-only blocks on units 0 and 1.
REQ-033 RR_PERSIST=1, two requests of 3 blocks each with NUM_RS_UNITS=4: response SHALL be units 0,1,2 then 3,0,1.
REQ-034 rst asserted mid-PAD: response SHALL be all outputs at their reset values asynchronously, and a fresh request then starting on unit 0.

Source files
------------

// File: rtl/rs_encode_pkg.sv
// Purpose: state encodings shared by the RS encode stream-in scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package rs_encode_pkg;

    // Main line scheduler: take request, stream data lines, issue pad lines, wait for metadata.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        PAD   = 2'd2,
        DRAIN = 2'd3
    } main_state_e;

    // Metadata handoff to the output controller, runs alongside the line stream.
    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_PASS = 2'd1,
        M_DONE = 2'd2
    } meta_state_e;

endpackage

// File: rtl/rs_encode_stream_in_sched_if.sv
// Purpose: request / data-line / unit / metadata signals of the RS stream-in scheduler.
// Latency: n/a (wiring only).
// Backpressure: val/rdy on request, data, unit and metadata channels.
interface rs_encode_stream_in_sched_if #(
    parameter int NUM_RS_UNITS   = 4,
    parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
    parameter int LINE_CNT_W     = 8,
    parameter int BLOCK_CNT_W    = 16
);
    logic                      src_req_val;
    logic                      src_req_rdy;
    logic [BLOCK_CNT_W-1:0]    src_req_num_blocks;
    logic [LINE_CNT_W-1:0]     src_req_lines;
    logic                      src_data_val;
    logic                      src_data_rdy;
    logic [NUM_RS_UNITS-1:0]   unit_val;
    logic [NUM_RS_UNITS-1:0]   unit_rdy;
    logic                      unit_pad;
    logic                      unit_last;
    logic [NUM_RS_UNITS_W-1:0] rs_unit_sel;
    logic                      meta_val;
    logic                      meta_rdy;
    logic                      busy;

    // Scheduler side.
    modport master (
        input  src_req_val, src_req_num_blocks, src_req_lines, src_data_val, unit_rdy, meta_rdy,
        output src_req_rdy, src_data_rdy, unit_val, unit_pad, unit_last, rs_unit_sel, meta_val, busy
    );

    // Environment side: request source, line source, RS units and output controller.
    modport slave (
        output src_req_val, src_req_num_blocks, src_req_lines, src_data_val, unit_rdy, meta_rdy,
        input  src_req_rdy, src_data_rdy, unit_val, unit_pad, unit_last, rs_unit_sel, meta_val, busy
    );
endinterface

// File: rtl/rs_rr_sel.sv
// Purpose: modulo-N round-robin unit selector with binary index and one-hot decode.
// Latency: index updates one cycle after clr/adv; decode is combinational.
// Backpressure: none; clr has priority over adv.
module rs_rr_sel #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    // Next index: restart at 0, or step with wrap from N-1 back to 0.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (adv) begin
            idx_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // One-hot decode of the current index.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (idx_q == W'(i));
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/rs_encode_stream_in_sched.sv
// Purpose: spreads request blocks round-robin over RS units: data lines, then pad lines, then metadata drain.
// Latency: data lines pass source->unit combinationally (zero cycles, no buffering).
// Backpressure: src_data_rdy mirrors the selected unit's ready; meta_rdy only stalls the final DRAIN.
module rs_encode_stream_in_sched
    import rs_encode_pkg::*;
#(
    parameter int NUM_RS_UNITS   = 4,
    parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
    parameter int LINE_CNT_W     = 8,
    parameter int BLOCK_CNT_W    = 16,
    parameter int PAD_LINES      = 1,
    parameter int RR_PERSIST     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    rs_encode_stream_in_sched_if.master bus
);
    localparam int PAD_CNT_W = (PAD_LINES > 1) ? $clog2(PAD_LINES) : 1;

    main_state_e             state_q, state_d;
    meta_state_e             meta_q, meta_d;
    logic [BLOCK_CNT_W-1:0]  num_blocks_q, num_blocks_d;
    logic [BLOCK_CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [LINE_CNT_W-1:0]   lines_q, lines_d;
    logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic [PAD_CNT_W-1:0]    pad_cnt_q, pad_cnt_d;

    logic                      sel_clr;
    logic                      sel_adv;
    logic [NUM_RS_UNITS_W-1:0] sel_idx;
    logic [NUM_RS_UNITS-1:0]   sel_onehot;

    logic req_hs;
    logic unit_rdy_sel;
    logic data_hs;
    logic pad_hs;
    logic last_line;
    logic last_pad;
    logic last_blk;

    rs_rr_sel #(
        .N (NUM_RS_UNITS),
        .W (NUM_RS_UNITS_W)
    ) u_rr_sel (
        .clk    (clk),
        .rst    (rst),
        .clr    (sel_clr),
        .adv    (sel_adv),
        .idx    (sel_idx),
        .onehot (sel_onehot)
    );

    // Unselected units' ready bits are masked out here.
    assign unit_rdy_sel = |(bus.unit_rdy & sel_onehot);
    assign req_hs       = (state_q == IDLE) && bus.src_req_val;
    assign data_hs      = (state_q == DATA) && bus.src_data_val && unit_rdy_sel;
    assign pad_hs       = (state_q == PAD) && unit_rdy_sel;
    assign last_line    = (line_cnt_q == lines_q - LINE_CNT_W'(1));
    assign last_pad     = (pad_cnt_q == PAD_CNT_W'(PAD_LINES - 1));
    assign last_blk     = (blk_cnt_q == num_blocks_q - BLOCK_CNT_W'(1));

    // Main scheduler next state: request latch, data/pad line counting, block advance.
    always_comb begin
        state_d      = state_q;
        num_blocks_d = num_blocks_q;
        lines_d      = lines_q;
        line_cnt_d   = line_cnt_q;
        pad_cnt_d    = pad_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        sel_clr      = 1'b0;
        sel_adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.src_req_val) begin
                    num_blocks_d = bus.src_req_num_blocks;
                    lines_d      = bus.src_req_lines;
                    line_cnt_d   = '0;
                    pad_cnt_d    = '0;
                    blk_cnt_d    = '0;
                    sel_clr      = (RR_PERSIST == 0);
                    if (bus.src_req_num_blocks == '0) begin
                        state_d = DRAIN;
                    end else if (bus.src_req_lines == '0) begin
                        state_d = PAD;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (data_hs) begin
                    if (last_line) begin
                        line_cnt_d = '0;
                        state_d    = PAD;
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
                    end
                end
            end
            PAD: begin
                if (pad_hs) begin
                    if (last_pad) begin
                        pad_cnt_d = '0;
                        blk_cnt_d = blk_cnt_q + BLOCK_CNT_W'(1);
                        // Advance also after the final block so a persistent selector moves on.
                        sel_adv   = 1'b1;
                        if (last_blk) begin
                            state_d = DRAIN;
                        end else if (lines_q == '0) begin
                            state_d = PAD;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        pad_cnt_d = pad_cnt_q + PAD_CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (meta_q == M_DONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Metadata handoff; never gates the line stream, only the exit from DRAIN.
    always_comb begin
        meta_d = meta_q;
        case (meta_q)
            M_IDLE:  if (req_hs) meta_d = M_PASS;
            M_PASS:  if (bus.meta_rdy) meta_d = M_DONE;
            M_DONE:  if (state_q == DRAIN) meta_d = M_IDLE;
            default: meta_d = M_IDLE;
        endcase
    end

    // State and counter registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            meta_q       <= M_IDLE;
            num_blocks_q <= '0;
            lines_q      <= '0;
            line_cnt_q   <= '0;
            pad_cnt_q    <= '0;
            blk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            meta_q       <= meta_d;
            num_blocks_q <= num_blocks_d;
            lines_q      <= lines_d;
            line_cnt_q   <= line_cnt_d;
            pad_cnt_q    <= pad_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign bus.src_req_rdy  = (state_q == IDLE);
    assign bus.src_data_rdy = (state_q == DATA) && unit_rdy_sel;
    assign bus.unit_val     = (state_q == DATA) ? ({NUM_RS_UNITS{bus.src_data_val}} & sel_onehot) :
                              (state_q == PAD)  ? sel_onehot : '0;
    assign bus.unit_pad     = (state_q == PAD);
    assign bus.unit_last    = (state_q == PAD) && last_pad;
    assign bus.rs_unit_sel  = sel_idx;
    assign bus.meta_val     = (meta_q == M_PASS);
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rs_encode_stream_in_sched.sv
module tb_rs_encode_stream_in_sched;
    localparam int NA = 3;
    localparam int WA = 2;
    localparam int NB = 4;
    localparam int WB = 2;

    typedef struct {
        int unit;
        bit pad;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   meta_a = 0;
    int   meta_b = 0;
    int   src_hs_a = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    logic          a_hold = 1'b0;
    logic          a_rand = 1'b0;
    logic [NA-1:0] a_rdy_rand = '1;

    always #5 clk = ~clk;

    rs_encode_stream_in_sched_if #(.NUM_RS_UNITS(NA), .NUM_RS_UNITS_W(WA), .LINE_CNT_W(8), .BLOCK_CNT_W(16)) ifa ();
    rs_encode_stream_in_sched_if #(.NUM_RS_UNITS(NB), .NUM_RS_UNITS_W(WB), .LINE_CNT_W(8), .BLOCK_CNT_W(16)) ifb ();

    rs_encode_stream_in_sched #(
        .NUM_RS_UNITS(NA), .NUM_RS_UNITS_W(WA), .LINE_CNT_W(8), .BLOCK_CNT_W(16),
        .PAD_LINES(1), .RR_PERSIST(0)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));

    rs_encode_stream_in_sched #(
        .NUM_RS_UNITS(NB), .NUM_RS_UNITS_W(WB), .LINE_CNT_W(8), .BLOCK_CNT_W(16),
        .PAD_LINES(2), .RR_PERSIST(1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    assign ifa.unit_rdy = a_hold ? '0 : a_rdy_rand;
    assign ifb.unit_rdy = '1;

    // Unit ready pattern for instance A: all ready, or random per unit.
    always @(posedge clk) begin
        #1;
        a_rdy_rand = a_rand ? NA'($urandom) : '1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected unit line sequence: per block, data lines then pad lines, last flag on final pad.
    task automatic push_exp(input int inst, input int nb, input int lines, input int start,
                            input int n, input int pads);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < lines + pads; l++) begin
                e.unit = (start + b) % n;
                e.pad  = (l >= lines);
                e.last = (l == lines + pads - 1);
                if (inst == 0) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
        end
    endtask

    task automatic mon_line(input int inst, input logic [7:0] val, input logic pad,
                            input logic last, input logic [7:0] sel);
        exp_t e;
        int   u;
        logic [31:0] got;
        logic [31:0] exp;
        u = 0;
        for (int i = 7; i >= 0; i--) if (val[i]) u = i;
        got = {8'd0, 4'd0, 4'($onehot(val)), 4'(u), 2'd0, pad, last, sel};
        if ((inst == 0 && exp_a.size() == 0) || (inst != 0 && exp_b.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected_line: got 0x%0h expected none", inst == 0 ? "a" : "b", got);
        end else begin
            e = (inst == 0) ? exp_a.pop_front() : exp_b.pop_front();
            exp = {8'd0, 4'd0, 4'd1, 4'(e.unit), 2'd0, e.pad, e.last, 8'(e.unit)};
            check(inst == 0 ? "a_line" : "b_line", got, exp);
        end
    endtask

    // Scoreboard monitor: every unit handshake pops one expected line.
    always @(negedge clk) begin
        if (!rst) begin
            if ((ifa.unit_val & ifa.unit_rdy) != '0)
                mon_line(0, 8'(ifa.unit_val), ifa.unit_pad, ifa.unit_last, 8'(ifa.rs_unit_sel));
            if ((ifb.unit_val & ifb.unit_rdy) != '0)
                mon_line(1, 8'(ifb.unit_val), ifb.unit_pad, ifb.unit_last, 8'(ifb.rs_unit_sel));
            if (ifa.meta_val && ifa.meta_rdy) meta_a++;
            if (ifb.meta_val && ifb.meta_rdy) meta_b++;
            if (ifa.src_data_val && ifa.src_data_rdy) src_hs_a++;
        end
    end

    task automatic chk_rst_a(input string p);
        check({p, "_req_rdy"},  32'(ifa.src_req_rdy), 32'd1);
        check({p, "_data_rdy"}, 32'(ifa.src_data_rdy), 32'd0);
        check({p, "_unit_val"}, 32'(ifa.unit_val), 32'd0);
        check({p, "_pad_last"}, 32'({ifa.unit_pad, ifa.unit_last}), 32'd0);
        check({p, "_sel"},      32'(ifa.rs_unit_sel), 32'd0);
        check({p, "_meta_val"}, 32'(ifa.meta_val), 32'd0);
        check({p, "_busy"},     32'(ifa.busy), 32'd0);
    endtask

    task automatic req_a(input int nb, input int lines);
        bit acc;
        int cyc;
        acc = 1'b0;
        cyc = 0;
        ifa.src_req_num_blocks = 16'(nb);
        ifa.src_req_lines      = 8'(lines);
        ifa.src_req_val        = 1'b1;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = ifa.src_req_rdy;
            @(posedge clk); #1;
            cyc++;
        end
        ifa.src_req_val = 1'b0;
        check("a_req_accept", 32'(acc), 32'd1);
    endtask

    task automatic data_a(input int total, input bit rnd);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < total && cyc < 20000) begin
            ifa.src_data_val = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (ifa.src_data_val && ifa.src_data_rdy) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        ifa.src_data_val = 1'b0;
        check("a_data_sent", 32'(sent), 32'(total));
    endtask

    // Returns on the clock edge that completes the last expected line.
    task automatic wait_empty_a();
        int cyc;
        cyc = 0;
        while (exp_a.size() != 0 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("a_lines_left", 32'(exp_a.size()), 32'd0);
    endtask

    task automatic wait_idle_a();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ifa.busy && cyc < 2000);
        check("a_idle", 32'(ifa.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic req_b(input int nb, input int lines, input int budget, input bit chk_first);
        bit acc;
        bit prev_busy;
        int cyc;
        acc = 1'b0;
        prev_busy = 1'b0;
        cyc = 0;
        ifb.src_req_num_blocks = 16'(nb);
        ifb.src_req_lines      = 8'(lines);
        ifb.src_req_val        = 1'b1;
        while (!acc && cyc < budget) begin
            @(negedge clk);
            acc = ifb.src_req_rdy;
            if (!acc) prev_busy = ifb.busy;
            @(posedge clk); #1;
            cyc++;
        end
        ifb.src_req_val = 1'b0;
        check("b_req_accept", 32'(acc), 32'd1);
        if (chk_first) check("b_accept_first_idle", 32'(prev_busy), 32'd1);
    endtask

    task automatic wait_idle_b();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ifb.busy && cyc < 2000);
        check("b_idle", 32'(ifb.busy), 32'd0);
        @(posedge clk); #1;
        check("b_lines_left", 32'(exp_b.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        ifa.src_req_val = 1'b0;
        ifa.src_req_num_blocks = '0;
        ifa.src_req_lines = '0;
        ifa.src_data_val = 1'b0;
        ifa.meta_rdy = 1'b1;
        ifb.src_req_val = 1'b0;
        ifb.src_req_num_blocks = '0;
        ifb.src_req_lines = '0;
        ifb.src_data_val = 1'b1;
        ifb.meta_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_rst_a("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Four blocks of 4 lines on 3 units: 0,1,2,0; one DRAIN cycle, then idle.
        push_exp(0, 4, 4, 0, NA, 1);
        req_a(4, 4);
        data_a(16, 1'b0);
        wait_empty_a();
        @(negedge clk);
        check("t1_drain_busy", 32'(ifa.busy), 32'd1);
        check("t1_drain_val", 32'({ifa.unit_val, ifa.src_data_rdy, ifa.src_req_rdy}), 32'd0);
        @(negedge clk);
        check("t1_idle_busy", 32'(ifa.busy), 32'd0);
        check("t1_idle_req_rdy", 32'(ifa.src_req_rdy), 32'd1);
        @(posedge clk); #1;

        // Random stalls on both source valid and unit ready, 255-line blocks.
        src_hs_a = 0;
        a_rand = 1'b1;
        push_exp(0, 2, 255, 0, NA, 1);
        req_a(2, 255);
        data_a(510, 1'b1);
        wait_empty_a();
        a_rand = 1'b0;
        wait_idle_a();
        check("t2_src_lines", 32'(src_hs_a), 32'd510);

        // Metadata held off: lines finish, block sits in DRAIN until meta accepted.
        ifa.meta_rdy = 1'b0;
        push_exp(0, 1, 2, 0, NA, 1);
        req_a(1, 2);
        data_a(2, 1'b0);
        wait_empty_a();
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("t3_wait_busy", 32'(ifa.busy), 32'd1);
        check("t3_wait_meta", 32'(ifa.meta_val), 32'd1);
        check("t3_wait_val", 32'({ifa.unit_val, ifa.src_data_rdy}), 32'd0);
        @(posedge clk); #1;
        ifa.meta_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_drain_after_meta", 32'(ifa.busy), 32'd1);
        @(negedge clk);
        check("t3_idle_after_meta", 32'(ifa.busy), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of the second block's pad line.
        push_exp(0, 2, 2, 0, NA, 1);
        req_a(2, 2);
        data_a(4, 1'b0);
        a_hold = 1'b1;
        @(negedge clk);
        check("t4_mid_pad", 32'({ifa.unit_pad, ifa.unit_last, ifa.rs_unit_sel, ifa.unit_val}), 32'b1_1_01_010);
        #2 rst = 1'b1;
        #1;
        chk_rst_a("async_rst");
        exp_a.delete();
        a_hold = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        push_exp(0, 1, 1, 0, NA, 1);
        req_a(1, 1);
        data_a(1, 1'b0);
        wait_empty_a();
        wait_idle_a();

        // Persistent round robin on 4 units: 0,1,2 then 3,0,1; second request taken on first idle cycle.
        push_exp(1, 3, 1, 0, NB, 2);
        push_exp(1, 3, 1, 3, NB, 2);
        req_b(3, 1, 20, 1'b0);
        req_b(3, 1, 500, 1'b1);
        wait_idle_b();

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Zero blocks: metadata only. Then zero lines: two pad-only blocks on units 0 and 1.
        req_b(0, 5, 20, 1'b0);
        wait_idle_b();
        check("t6_meta_only", 32'(meta_b), 32'd3);
        push_exp(1, 2, 0, 0, NB, 2);
        req_b(2, 0, 20, 1'b0);
        wait_idle_b();

        check("a_meta_count", 32'(meta_a), 32'd5);
        check("b_meta_count", 32'(meta_b), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
